// File: rtl/mem_seq_pkg.sv
// Shared definitions for the Avalon-MM address sequencer: FSM state encoding
// and the default parameter values used by the top level.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD        = 3'd1,
        WAIT_DATA = 3'd2,
        WR        = 3'd3,
        ROW_ADV   = 3'd4,
        DONE      = 3'd5
    } state_e;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DIM_W      = 16;
    localparam int DEF_N_ROWS     = 3;
    localparam int DEF_WORD_BYTES = 4;

endpackage

// File: rtl/strobe_edge_det.sv
// Rising-edge detector for a level strobe: one history register plus an AND.
module strobe_edge_det (
    input  logic clk,
    input  logic n_rst,
    input  logic strobe,
    output logic rise
);

    logic strobe_d;
    logic strobe_q;

    // Next history value is simply the current strobe level.
    always_comb begin
        strobe_d = strobe;
    end

    // Remember last cycle's strobe level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/mem_addr_sequencer.sv
// Avalon-MM address sequencer: per column issues N_ROWS vertically adjacent
// reads, waits for the datapath result, then issues one write; walks the
// frame column by column and row by row. All request outputs are registered.
module mem_addr_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DIM_W      = DEF_DIM_W,
    parameter int N_ROWS     = DEF_N_ROWS,
    parameter int WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] read_base,
    input  logic [ADDR_W-1:0] write_base,
    input  logic [DIM_W-1:0]  n_columns,
    input  logic [DIM_W-1:0]  n_lines,
    input  logic              wr_data_ok,
    input  logic              avm_waitrequest,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic              busy,
    output logic              done,
    output logic [DIM_W-1:0]  col_idx,
    output logic [DIM_W-1:0]  row_idx
);

    localparam int RD_CNT_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [RD_CNT_W-1:0] LAST_RD = RD_CNT_W'(N_ROWS - 1);

    logic start_rise;

    state_e              state_q,       state_d;
    logic [ADDR_W-1:0]   row_base_q [N_ROWS];
    logic [ADDR_W-1:0]   row_base_d [N_ROWS];
    logic [ADDR_W-1:0]   wr_base_q,     wr_base_d;
    logic [ADDR_W-1:0]   col_off_q,     col_off_d;
    logic [ADDR_W-1:0]   stride_q,      stride_d;
    logic [RD_CNT_W-1:0] rd_cnt_q,      rd_cnt_d;
    logic [DIM_W-1:0]    last_col_q,    last_col_d;
    logic [DIM_W-1:0]    last_row_q,    last_row_d;
    logic [DIM_W-1:0]    col_idx_q,     col_idx_d;
    logic [DIM_W-1:0]    row_idx_q,     row_idx_d;
    logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
    logic                avm_read_q,    avm_read_d;
    logic                avm_write_q,   avm_write_d;
    logic                busy_q,        busy_d;
    logic                done_q,        done_d;
    logic [ADDR_W-1:0]   launch_acc;

    strobe_edge_det u_start_edge (
        .clk    (clk),
        .n_rst  (n_rst),
        .strobe (start),
        .rise   (start_rise)
    );

    // Next-state, address bookkeeping and the registered request outputs.
    always_comb begin
        state_d    = state_q;
        wr_base_d  = wr_base_q;
        col_off_d  = col_off_q;
        stride_d   = stride_q;
        rd_cnt_d   = rd_cnt_q;
        last_col_d = last_col_q;
        last_row_d = last_row_q;
        col_idx_d  = col_idx_q;
        row_idx_d  = row_idx_q;
        launch_acc = read_base;
        for (int r = 0; r < N_ROWS; r++) begin
            row_base_d[r] = row_base_q[r];
        end

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    // Line starts are built with an adder chain from read_base.
                    stride_d = ADDR_W'(n_columns) * ADDR_W'(WORD_BYTES);
                    for (int r = 0; r < N_ROWS; r++) begin
                        row_base_d[r] = launch_acc;
                        launch_acc    = launch_acc + stride_d;
                    end
                    wr_base_d  = write_base;
                    col_off_d  = '0;
                    rd_cnt_d   = '0;
                    col_idx_d  = '0;
                    row_idx_d  = '0;
                    last_col_d = n_columns - DIM_W'(1);
                    last_row_d = n_lines - DIM_W'(N_ROWS);
                    if (n_columns == '0 || n_lines < DIM_W'(N_ROWS)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (!avm_waitrequest) begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (rd_cnt_q == LAST_RD) begin
                        rd_cnt_d = '0;
                        state_d  = WAIT_DATA;
                    end else begin
                        rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
                    end
                end
            end
            WAIT_DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (wr_data_ok) begin
                    state_d = WR;
                end
            end
            WR: begin
                if (!avm_waitrequest) begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (col_idx_q < last_col_q) begin
                        col_idx_d = col_idx_q + DIM_W'(1);
                        col_off_d = col_off_q + ADDR_W'(WORD_BYTES);
                        state_d   = RD;
                    end else begin
                        state_d = ROW_ADV;
                    end
                end
            end
            ROW_ADV: begin
                for (int r = 0; r < N_ROWS; r++) begin
                    row_base_d[r] = row_base_q[r] + stride_q;
                end
                wr_base_d = wr_base_q + stride_q;
                col_off_d = '0;
                col_idx_d = '0;
                row_idx_d = row_idx_q + DIM_W'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (row_idx_q == last_row_q) begin
                    state_d = DONE;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register in step with it.
        avm_read_d    = (state_d == RD);
        avm_write_d   = (state_d == WR);
        busy_d        = (state_d inside {RD, WAIT_DATA, WR, ROW_ADV});
        done_d        = (state_d == DONE);
        avm_address_d = avm_address_q;
        if (state_d == RD) begin
            avm_address_d = row_base_d[rd_cnt_d] + col_off_d;
        end else if (state_d == WR) begin
            avm_address_d = wr_base_d + col_off_d;
        end
    end

    // FSM state, address bases and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            wr_base_q     <= '0;
            col_off_q     <= '0;
            stride_q      <= '0;
            rd_cnt_q      <= '0;
            last_col_q    <= '0;
            last_row_q    <= '0;
            col_idx_q     <= '0;
            row_idx_q     <= '0;
            avm_address_q <= '0;
            avm_read_q    <= 1'b0;
            avm_write_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            for (int r = 0; r < N_ROWS; r++) begin
                row_base_q[r] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_base_q     <= wr_base_d;
            col_off_q     <= col_off_d;
            stride_q      <= stride_d;
            rd_cnt_q      <= rd_cnt_d;
            last_col_q    <= last_col_d;
            last_row_q    <= last_row_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            avm_address_q <= avm_address_d;
            avm_read_q    <= avm_read_d;
            avm_write_q   <= avm_write_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            for (int r = 0; r < N_ROWS; r++) begin
                row_base_q[r] <= row_base_d[r];
            end
        end
    end

    assign avm_address = avm_address_q;
    assign avm_read    = avm_read_q;
    assign avm_write   = avm_write_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign col_idx     = col_idx_q;
    assign row_idx     = row_idx_q;

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Bench for mem_addr_sequencer: a transaction-list reference model built from
// pixel coordinates, randomized stalls, plus directed frames.
module tb_mem_addr_sequencer;

    localparam int NR = 3;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic        abort;
    logic [31:0] read_base;
    logic [31:0] write_base;
    logic [15:0] n_columns;
    logic [15:0] n_lines;
    logic        wr_data_ok;
    logic        avm_waitrequest;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic        busy;
    logic        done;
    logic [15:0] col_idx;
    logic [15:0] row_idx;

    int n_cmp = 0;
    int n_err = 0;

    mem_addr_sequencer #(
        .ADDR_W     (32),
        .DIM_W      (16),
        .N_ROWS     (NR),
        .WORD_BYTES (4)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .start           (start),
        .abort           (abort),
        .read_base       (read_base),
        .write_base      (write_base),
        .n_columns       (n_columns),
        .n_lines         (n_lines),
        .wr_data_ok      (wr_data_ok),
        .avm_waitrequest (avm_waitrequest),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .busy            (busy),
        .done            (done),
        .col_idx         (col_idx),
        .row_idx         (row_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Runs one frame from its start edge (cycle 0) to the done pulse, checking every
    // request against an address list computed from pixel coordinates.
    task automatic run_frame(
        input  logic [31:0]       rb,
        input  logic [31:0]       wb,
        input  int                cols,
        input  int                lines,
        input  int                wait_pct,
        input  int                data_pct,
        input  int                hold_txn,
        input  int                hold_cyc,
        input  int                dstall_wr,
        input  int                dstall_cyc,
        output int                done_cyc,
        output int                n_rd,
        output int                n_wr,
        output logic [31:0]       last_wr,
        output int                first_wr_cyc,
        output logic [2:0][31:0]  first_rds
    );
        logic        exp_wr[$];
        logic [31:0] exp_addr[$];
        logic [31:0] stride;
        int          rows;
        int          base;
        int          stalls;
        int          acc_idx;
        int          hold_left;
        int          dstall_left;
        bit          fin;
        bit          req;

        stride = 32'(cols) * 32'd4;
        rows   = lines - (NR - 1);
        if (cols > 0 && rows > 0) begin
            for (int y = 0; y < rows; y++) begin
                for (int x = 0; x < cols; x++) begin
                    for (int r = 0; r < NR; r++) begin
                        exp_wr.push_back(1'b0);
                        exp_addr.push_back(rb + 32'(y + r) * stride + 32'(x) * 32'd4);
                    end
                    exp_wr.push_back(1'b1);
                    exp_addr.push_back(wb + 32'(y) * stride + 32'(x) * 32'd4);
                end
            end
            base = rows * (cols * (NR + 2) + 1);
        end else begin
            base = 0;
        end

        stalls       = 0;
        acc_idx      = 0;
        hold_left    = hold_cyc;
        dstall_left  = dstall_cyc;
        done_cyc     = -1;
        n_rd         = 0;
        n_wr         = 0;
        last_wr      = '0;
        first_wr_cyc = -1;
        first_rds    = '0;
        fin          = 1'b0;

        @(posedge clk); #1;
        read_base       = rb;
        write_base      = wb;
        n_columns       = 16'(cols);
        n_lines         = 16'(lines);
        start           = 1'b1;
        abort           = 1'b0;
        avm_waitrequest = 1'b0;
        wr_data_ok      = 1'b1;

        for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            req   = avm_read | avm_write;
            if (done) begin
                check_eq("done_cycle", 32'(cyc), 32'(base + stalls + 1));
                check_eq("done_busy", 32'(busy), 32'd0);
                check_eq("done_req", 32'(req), 32'd0);
                check_eq("txn_left", 32'(exp_addr.size()), 32'd0);
                done_cyc = cyc;
                fin      = 1'b1;
            end else if (!busy) begin
                check_eq("busy_high", 32'(busy), 32'd1);
                fin = 1'b1;
            end else begin
                check_eq("rd_wr_excl", 32'(avm_read & avm_write), 32'd0);
                if (req) begin
                    if (exp_addr.size() == 0) begin
                        check_eq("extra_req", 32'(req), 32'd0);
                        fin = 1'b1;
                    end else begin
                        if (avm_write) check_eq("wr_addr", avm_address, exp_addr[0]);
                        else           check_eq("rd_addr", avm_address, exp_addr[0]);
                        check_eq("req_kind", 32'(avm_write), 32'(exp_wr[0]));
                        if (hold_left > 0 && acc_idx == hold_txn) begin
                            avm_waitrequest = 1'b1;
                            hold_left--;
                        end else begin
                            avm_waitrequest = ($urandom_range(99) < wait_pct);
                        end
                        wr_data_ok = 1'($urandom_range(1));
                        if (avm_waitrequest) begin
                            stalls++;
                        end else begin
                            if (avm_write) begin
                                n_wr++;
                                last_wr = avm_address;
                                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                            end else begin
                                if (n_rd < 3) first_rds[n_rd] = avm_address;
                                n_rd++;
                            end
                            void'(exp_wr.pop_front());
                            void'(exp_addr.pop_front());
                            acc_idx++;
                        end
                    end
                end else begin
                    avm_waitrequest = 1'($urandom_range(1));
                    if (exp_wr.size() > 0 && exp_wr[0]) begin
                        // All reads of the column are done: waiting for the result word.
                        if (dstall_left > 0 && n_wr == dstall_wr) begin
                            wr_data_ok = 1'b0;
                            dstall_left--;
                        end else begin
                            wr_data_ok = ($urandom_range(99) >= data_pct);
                        end
                        if (!wr_data_ok) stalls++;
                    end else begin
                        wr_data_ok = 1'($urandom_range(1));
                    end
                end
            end
        end
        if (!fin) check_eq("frame_timeout", 32'(fin), 32'd1);
        avm_waitrequest = 1'b0;
        wr_data_ok      = 1'b1;
        if (done_cyc > 0) begin
            @(posedge clk); #1;
            check_eq("done_pulse_len", 32'(done), 32'd0);
        end
    endtask

    int               d_cyc;
    int               nrd;
    int               nwr;
    logic [31:0]      lwr;
    int               fwc;
    logic [2:0][31:0] frds;

    initial begin
        n_rst           = 1'b0;
        start           = 1'b0;
        abort           = 1'b0;
        read_base       = '0;
        write_base      = '0;
        n_columns       = '0;
        n_lines         = '0;
        wr_data_ok      = 1'b1;
        avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_addr", avm_address, 32'd0);
        check_eq("rst_read", 32'(avm_read), 32'd0);
        check_eq("rst_write", 32'(avm_write), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_col", 32'(col_idx), 32'd0);
        check_eq("rst_row", 32'(row_idx), 32'd0);
        n_rst = 1'b1;

        // Nominal zero-wait frame.
        run_frame(32'h1000, 32'h8000, 4, 5, 0, 0, -1, 0, -1, 0, d_cyc, nrd, nwr, lwr, fwc, frds);
        check_eq("nom_done", 32'(d_cyc), 32'd64);
        check_eq("nom_reads", 32'(nrd), 32'd36);
        check_eq("nom_writes", 32'(nwr), 32'd12);
        check_eq("nom_last_wr", lwr, 32'h802C);
        check_eq("nom_first_wr", 32'(fwc), 32'd5);
        check_eq("nom_rd0", frds[0], 32'h1000);
        check_eq("nom_rd1", frds[1], 32'h1010);
        check_eq("nom_rd2", frds[2], 32'h1020);

        // Three waitrequest cycles on the second read.
        run_frame(32'h1000, 32'h8000, 4, 5, 0, 0, 1, 3, -1, 0, d_cyc, nrd, nwr, lwr, fwc, frds);
        check_eq("wait_done", 32'(d_cyc), 32'd67);

        // Result word late by five cycles at column 2.
        run_frame(32'h1000, 32'h8000, 4, 5, 0, 0, -1, 0, 2, 5, d_cyc, nrd, nwr, lwr, fwc, frds);
        check_eq("dstall_done", 32'(d_cyc), 32'd69);

        // Degenerate frames.
        run_frame(32'h1000, 32'h8000, 4, 2, 0, 0, -1, 0, -1, 0, d_cyc, nrd, nwr, lwr, fwc, frds);
        check_eq("degen_lines_done", 32'(d_cyc), 32'd1);
        check_eq("degen_lines_req", 32'(nrd + nwr), 32'd0);
        run_frame(32'h1000, 32'h8000, 0, 5, 0, 0, -1, 0, -1, 0, d_cyc, nrd, nwr, lwr, fwc, frds);
        check_eq("degen_cols_done", 32'(d_cyc), 32'd1);
        check_eq("degen_cols_req", 32'(nrd + nwr), 32'd0);

        // Address wrap-around.
        run_frame(32'hFFFF_FFF8, 32'h8000, 4, 3, 0, 0, -1, 0, -1, 0, d_cyc, nrd, nwr, lwr, fwc, frds);
        check_eq("wrap_rd0", frds[0], 32'hFFFF_FFF8);
        check_eq("wrap_rd1", frds[1], 32'h0000_0008);
        check_eq("wrap_rd2", frds[2], 32'h0000_0018);

        // Abort during a stalled write, with a stray start edge mid-frame.
        @(posedge clk); #1;
        read_base = 32'h1000; write_base = 32'h8000; n_columns = 16'd4; n_lines = 16'd5;
        start = 1'b1; abort = 1'b0; avm_waitrequest = 1'b0; wr_data_ok = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("ab_rd0", avm_address, 32'h1000);
        @(posedge clk); #1;
        check_eq("ab_rd1", avm_address, 32'h1010);
        start = 1'b1;
        @(posedge clk); #1;
        check_eq("ab_rd2", avm_address, 32'h1020);
        check_eq("ab_rd2_req", 32'(avm_read), 32'd1);
        @(posedge clk); #1;
        check_eq("ab_wait_req", 32'({avm_read, avm_write}), 32'd0);
        check_eq("ab_wait_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check_eq("ab_wr", 32'(avm_write), 32'd1);
        check_eq("ab_wr_addr", avm_address, 32'h8000);
        avm_waitrequest = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("ab_wr_held", 32'(avm_write), 32'd1);
            check_eq("ab_wr_held_addr", avm_address, 32'h8000);
            check_eq("ab_held_busy", 32'(busy), 32'd1);
        end
        avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        check_eq("ab_idle_busy", 32'(busy), 32'd0);
        check_eq("ab_idle_req", 32'({avm_read, avm_write}), 32'd0);
        check_eq("ab_idle_done", 32'(done), 32'd0);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("ab_no_done", 32'(done), 32'd0);
            check_eq("ab_stay_idle", 32'(busy), 32'd0);
        end
        start = 1'b0;

        // Asynchronous reset in the middle of a frame.
        @(posedge clk); #1;
        start = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_eq("ar_pre_busy", 32'(busy), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check_eq("ar_addr", avm_address, 32'd0);
        check_eq("ar_req", 32'({avm_read, avm_write}), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_col", 32'(col_idx), 32'd0);
        check_eq("ar_row", 32'(row_idx), 32'd0);
        @(posedge clk); #2;
        n_rst = 1'b1;

        // Randomized frames with random stalls.
        for (int k = 0; k < 8; k++) begin
            run_frame($urandom, $urandom, int'($urandom_range(6)), int'($urandom_range(7)),
                      25, 25, -1, 0, -1, 0, d_cyc, nrd, nwr, lwr, fwc, frds);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
